// File: rtl/tmr_recovery_ctrl.sv
// Recovery controller downstream of a TMR voter: resyncs a single faulty core or rolls all cores back to a checkpoint.
// Optional per-core fault counters are built only when TMR_FAULT_LOG_EN is defined.
module tmr_recovery_ctrl #(
  parameter int          CKPT_INTERVAL = 64,
  parameter int          RESYNC_CYCLES = 8,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          MAX_ROLLBACK  = 3,
  parameter int          FAULT_CNT_W   = 8,
  parameter logic [31:0] PC_RESET      = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [2:0]             Voter_state,
  input  logic [31:0]            PC_Top,
  output logic                   Stall,
  output logic [2:0]             Core_rst,
  output logic                   PC_Load,
  output logic [31:0]            PC_Override,
  output logic [1:0]             Faulty_core,
  output logic [FAULT_CNT_W-1:0] Fault_cnt_A,
  output logic [FAULT_CNT_W-1:0] Fault_cnt_B,
  output logic [FAULT_CNT_W-1:0] Fault_cnt_C,
  output logic                   Fatal
);

  localparam int CKPT_W  = $clog2(CKPT_INTERVAL + 1);
  localparam int RB_W    = $clog2(MAX_ROLLBACK + 1);
  localparam int TMR_MAX = (RESYNC_CYCLES > SETTLE_CYCLES) ? RESYNC_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CKPT_W-1:0] CKPT_LAST   = CKPT_W'(CKPT_INTERVAL - 1);
  localparam logic [RB_W-1:0]   RB_LIMIT    = RB_W'(MAX_ROLLBACK);
  localparam logic [TMR_W-1:0]  RESYNC_LAST = TMR_W'(RESYNC_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_RESYNC = 3'd1,
    ST_RELOAD = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FATAL  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_ROLL   = 1'b1
  } mode_t;

  // Single-fault voter patterns name the odd core out; everything else maps to 0.
  function automatic logic [1:0] faulty_of(input logic [2:0] vs);
    logic [1:0] idx;
    case (vs)
      3'b010:  idx = 2'd1;
      3'b001:  idx = 2'd2;
      3'b100:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] core_mask(input logic [1:0] idx);
    logic [2:0] mask;
    case (idx)
      2'd1:    mask = 3'b100;
      2'd2:    mask = 3'b010;
      2'd3:    mask = 3'b001;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  state_t             state_r, state_s;
  mode_t              mode_r, mode_s;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic [CKPT_W-1:0]  ckpt_cnt_r, ckpt_cnt_s;
  logic [RB_W-1:0]    rb_cnt_r, rb_cnt_s, rb_inc_s;
  logic [31:0]        ckpt_pc_r, ckpt_pc_s;
  logic [31:0]        cap_pc_r, cap_pc_s;
  logic [1:0]         faulty_s;

  logic               stall_s;
  logic [2:0]         core_rst_s;
  logic               pc_load_s;
  logic [31:0]        pc_override_s;
  logic               fatal_s;

  // Next-state, checkpoint and recovery bookkeeping.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    timer_s    = timer_r;
    ckpt_cnt_s = ckpt_cnt_r;
    rb_cnt_s   = rb_cnt_r;
    rb_inc_s   = rb_cnt_r + RB_W'(1);
    ckpt_pc_s  = ckpt_pc_r;
    cap_pc_s   = cap_pc_r;
    faulty_s   = Faulty_core;
    case (state_r)
      ST_NORMAL: begin
        case (Voter_state)
          3'b111: begin
            if (ckpt_cnt_r == CKPT_LAST) begin
              ckpt_pc_s  = PC_Top;
              ckpt_cnt_s = '0;
              rb_cnt_s   = '0;
            end else begin
              ckpt_cnt_s = ckpt_cnt_r + CKPT_W'(1);
            end
          end
          3'b010, 3'b001, 3'b100: begin
            cap_pc_s   = PC_Top;
            faulty_s   = faulty_of(Voter_state);
            ckpt_cnt_s = '0;
            mode_s     = MODE_SINGLE;
            timer_s    = '0;
            state_s    = ST_RESYNC;
          end
          default: begin
            faulty_s   = 2'd0;
            ckpt_cnt_s = '0;
            rb_cnt_s   = rb_inc_s;
            if (rb_inc_s >= RB_LIMIT) begin
              state_s = ST_FATAL;
            end else begin
              mode_s  = MODE_ROLL;
              timer_s = '0;
              state_s = ST_RESYNC;
            end
          end
        endcase
      end
      ST_RESYNC: begin
        if (timer_r == RESYNC_LAST) begin
          timer_s = '0;
          state_s = ST_RELOAD;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      ST_RELOAD: begin
        timer_s = '0;
        if (SETTLE_CYCLES == 0) begin
          state_s = ST_NORMAL;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_r == SETTLE_LAST) begin
          timer_s = '0;
          state_s = ST_NORMAL;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      ST_FATAL: begin
        state_s = ST_FATAL;
      end
      default: begin
        state_s = ST_NORMAL;
      end
    endcase
  end

  // Output values decoded from the upcoming state so the registered outputs line up with it.
  always_comb begin
    stall_s       = 1'b0;
    core_rst_s    = 3'b000;
    pc_load_s     = 1'b0;
    fatal_s       = 1'b0;
    pc_override_s = PC_Override;
    case (state_s)
      ST_RESYNC: begin
        stall_s = 1'b1;
        if (mode_s == MODE_ROLL) begin
          core_rst_s = 3'b111;
        end else begin
          core_rst_s = core_mask(faulty_s);
        end
      end
      ST_RELOAD: begin
        stall_s   = 1'b1;
        pc_load_s = 1'b1;
        if (mode_s == MODE_ROLL) begin
          pc_override_s = ckpt_pc_r;
        end else begin
          pc_override_s = cap_pc_r;
        end
      end
      ST_FATAL: begin
        stall_s    = 1'b1;
        core_rst_s = 3'b111;
        fatal_s    = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_NORMAL;
      mode_r      <= MODE_SINGLE;
      timer_r     <= '0;
      ckpt_cnt_r  <= '0;
      rb_cnt_r    <= '0;
      ckpt_pc_r   <= PC_RESET;
      cap_pc_r    <= PC_RESET;
      Faulty_core <= 2'd0;
      Stall       <= 1'b0;
      Core_rst    <= 3'b000;
      PC_Load     <= 1'b0;
      PC_Override <= 32'h0;
      Fatal       <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      timer_r     <= timer_s;
      ckpt_cnt_r  <= ckpt_cnt_s;
      rb_cnt_r    <= rb_cnt_s;
      ckpt_pc_r   <= ckpt_pc_s;
      cap_pc_r    <= cap_pc_s;
      Faulty_core <= faulty_s;
      Stall       <= stall_s;
      Core_rst    <= core_rst_s;
      PC_Load     <= pc_load_s;
      PC_Override <= pc_override_s;
      Fatal       <= fatal_s;
    end
  end

`ifdef TMR_FAULT_LOG_EN
  logic [FAULT_CNT_W-1:0] cnt_a_r, cnt_b_r, cnt_c_r;
  logic [2:0]             hit_s;

  assign hit_s = (state_r == ST_NORMAL) ? core_mask(faulty_of(Voter_state)) : 3'b000;

  // Saturating per-core fault counters.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
      cnt_c_r <= '0;
    end else begin
      if (hit_s[2] && (cnt_a_r != '1)) begin
        cnt_a_r <= cnt_a_r + FAULT_CNT_W'(1);
      end
      if (hit_s[1] && (cnt_b_r != '1)) begin
        cnt_b_r <= cnt_b_r + FAULT_CNT_W'(1);
      end
      if (hit_s[0] && (cnt_c_r != '1)) begin
        cnt_c_r <= cnt_c_r + FAULT_CNT_W'(1);
      end
    end
  end

  assign Fault_cnt_A = cnt_a_r;
  assign Fault_cnt_B = cnt_b_r;
  assign Fault_cnt_C = cnt_c_r;
`else
  assign Fault_cnt_A = '0;
  assign Fault_cnt_B = '0;
  assign Fault_cnt_C = '0;
`endif

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Randomized bench for tmr_recovery_ctrl against a queue-based model of the recovery schedule.
module tb_tmr_recovery_ctrl;

  localparam int CKPT  = 64;
  localparam int RSY   = 8;
  localparam int STL   = 2;
  localparam int MAXRB = 3;
`ifdef TMR_FAULT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [2:0]  Voter_state = 3'b111;
  logic [31:0] PC_Top = 32'h0;
  logic        Stall, PC_Load, Fatal;
  logic [2:0]  Core_rst;
  logic [31:0] PC_Override;
  logic [1:0]  Faulty_core;
  logic [7:0]  Fault_cnt_A, Fault_cnt_B, Fault_cnt_C;

  tmr_recovery_ctrl dut (
    .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .PC_Top(PC_Top),
    .Stall(Stall), .Core_rst(Core_rst), .PC_Load(PC_Load), .PC_Override(PC_Override),
    .Faulty_core(Faulty_core), .Fault_cnt_A(Fault_cnt_A), .Fault_cnt_B(Fault_cnt_B),
    .Fault_cnt_C(Fault_cnt_C), .Fatal(Fatal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [2:0]  rst;
    logic        load;
    logic [31:0] pc;
  } exp_t;

  exp_t        plan_q[$];
  int          m_run, m_rolls;
  int          m_cnt[3];
  logic [31:0] m_ckpt;
  logic        m_fatal;
  logic [1:0]  m_faulty;
  logic        e_stall, e_load, e_fatal;
  logic [2:0]  e_rst;
  logic [31:0] e_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    plan_q.delete();
    m_run = 0; m_rolls = 0; m_ckpt = 32'h0; m_fatal = 1'b0; m_faulty = 2'd0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    e_stall = 1'b0; e_rst = 3'b000; e_load = 1'b0; e_fatal = 1'b0; e_pc = 32'h0;
  endtask

  // A recovery is a fixed timeline: reset pulse, one reload, then settling cycles
  // (plus the edge leaving settle) during which the voter is not looked at.
  task automatic plan_recovery(input logic [2:0] mask, input logic [31:0] pc);
    for (int i = 0; i < RSY; i++) plan_q.push_back('{1'b1, mask, 1'b0, 32'h0});
    plan_q.push_back('{1'b1, 3'b000, 1'b1, pc});
    for (int i = 0; i < STL + 1; i++) plan_q.push_back('{1'b0, 3'b000, 1'b0, 32'h0});
  endtask

  task automatic model_edge(input logic [2:0] vs, input logic [31:0] pc);
    exp_t e;
    int   idx;
    if (!m_fatal && plan_q.size() == 0) begin
      if (vs == 3'b111) begin
        m_run++;
        if (m_run == CKPT) begin
          m_ckpt = pc; m_run = 0; m_rolls = 0;
        end
      end else if (vs == 3'b010 || vs == 3'b001 || vs == 3'b100) begin
        idx = (vs == 3'b010) ? 1 : (vs == 3'b001) ? 2 : 3;
        m_faulty = idx[1:0];
        m_run = 0;
        if (m_cnt[idx-1] < 255) m_cnt[idx-1]++;
        plan_recovery(3'b100 >> (idx - 1), pc);
      end else begin
        m_faulty = 2'd0;
        m_run = 0;
        m_rolls++;
        if (m_rolls >= MAXRB) m_fatal = 1'b1;
        else plan_recovery(3'b111, m_ckpt);
      end
    end
    if (m_fatal) begin
      e_stall = 1'b1; e_rst = 3'b111; e_load = 1'b0; e_fatal = 1'b1;
    end else if (plan_q.size() > 0) begin
      e = plan_q.pop_front();
      e_stall = e.stall; e_rst = e.rst; e_load = e.load;
      if (e.load) e_pc = e.pc;
    end else begin
      e_stall = 1'b0; e_rst = 3'b000; e_load = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("Stall", {31'h0, Stall}, {31'h0, e_stall});
    check("Core_rst", {29'h0, Core_rst}, {29'h0, e_rst});
    check("PC_Load", {31'h0, PC_Load}, {31'h0, e_load});
    check("PC_Override", PC_Override, e_pc);
    check("Faulty_core", {30'h0, Faulty_core}, {30'h0, m_faulty});
    check("Fault_cnt_A", {24'h0, Fault_cnt_A}, LOG_EN ? m_cnt[0] : 0);
    check("Fault_cnt_B", {24'h0, Fault_cnt_B}, LOG_EN ? m_cnt[1] : 0);
    check("Fault_cnt_C", {24'h0, Fault_cnt_C}, LOG_EN ? m_cnt[2] : 0);
    check("Fatal", {31'h0, Fatal}, {31'h0, e_fatal});
  endtask

  task automatic step(input logic [2:0] vs, input logic [31:0] pc);
    @(negedge clk);
    Voter_state = vs;
    PC_Top = pc;
    @(posedge clk);
    #1;
    model_edge(vs, pc);
    compare_all();
  endtask

  task automatic step_rand(input int n);
    for (int i = 0; i < n; i++) step(3'($urandom_range(0, 7)), $urandom);
  endtask

  // Reset is raised mid-cycle so the clear is seen without any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #2;
    rst_in = 1'b0;
  endtask

  initial begin
    model_reset();
    pulse_reset();

    for (int i = 0; i < CKPT - 1; i++) step(3'b111, $urandom);
    step(3'b111, 32'h100);

    step(3'b010, 32'h240);
    check("lit_a_stall", {31'h0, Stall}, 32'd1);
    check("lit_a_rst", {29'h0, Core_rst}, 32'h4);
    check("lit_a_faulty", {30'h0, Faulty_core}, 32'd1);
    check("lit_a_cnt", {24'h0, Fault_cnt_A}, LOG_EN ? 32'd1 : 32'd0);
    for (int i = 1; i <= 11; i++) begin
      step(3'($urandom_range(0, 7)), $urandom);
      if (i == 8) begin
        check("lit_a_load", {31'h0, PC_Load}, 32'd1);
        check("lit_a_pc", PC_Override, 32'h240);
      end
      if (i == 9) check("lit_a_stall_low", {31'h0, Stall}, 32'd0);
    end

    step(3'b000, $urandom);
    check("lit_r_rst", {29'h0, Core_rst}, 32'h7);
    check("lit_r_faulty", {30'h0, Faulty_core}, 32'd0);
    for (int i = 1; i <= 11; i++) begin
      step(3'($urandom_range(0, 7)), $urandom);
      if (i == 8) check("lit_r_pc", PC_Override, 32'h100);
    end
    step(3'b000, $urandom);
    step_rand(11);
    step(3'b000, $urandom);
    check("lit_fatal", {31'h0, Fatal}, 32'd1);
    step_rand(5);
    check("lit_fatal_stall", {31'h0, Stall}, 32'd1);
    pulse_reset();
    check("lit_reset_fatal", {31'h0, Fatal}, 32'd0);

    for (int n = 0; n < 3000; ) begin
      if (m_fatal) begin
        step_rand(3);
        pulse_reset();
        n += 4;
      end else if ($urandom_range(0, 9) < 2) begin
        int len = $urandom_range(55, 70);
        for (int k = 0; k < len; k++) step(3'b111, $urandom);
        n += len;
      end else begin
        step(($urandom_range(0, 9) < 6) ? 3'($urandom_range(0, 7)) : 3'b111, $urandom);
        n++;
      end
    end

    pulse_reset();
    step(3'b001, 32'h55);
    step_rand(3);
    check("lit_mid_stall", {31'h0, Stall}, 32'd1);
    pulse_reset();
    check("lit_async_stall", {31'h0, Stall}, 32'd0);
    check("lit_async_rst", {29'h0, Core_rst}, 32'd0);
    step(3'b111, 32'h10);
    check("lit_post_rst_stall", {31'h0, Stall}, 32'd0);

    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      step(3'b100, $urandom);
      for (int k = 0; k < 11; k++) step(3'b111, $urandom);
    end
    check("lit_sat_c", {24'h0, Fault_cnt_C}, LOG_EN ? 32'd255 : 32'd0);
    check("lit_sat_faulty", {30'h0, Faulty_core}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
